// File: rtl/ssd_pkg.sv
// Shared constants, FSM encoding and leading-zero helper for the seven-segment path.
package ssd_pkg;

    localparam int unsigned SSD_DIGITS    = 4;
    localparam int unsigned SSD_MAX_VAL   = 9999;
    localparam logic [3:0]  SSD_OVF_DIGIT = 4'hF;
    localparam int unsigned SSD_BCD_W     = SSD_DIGITS * 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } ssd_state_e;

    // Digit i is lit iff it or any more significant digit is nonzero; ones always lit.
    function automatic logic [SSD_DIGITS-1:0] lz_enables(input logic [SSD_BCD_W-1:0] bcd);
        logic [SSD_DIGITS-1:0] en;
        logic                  any;
        any = 1'b0;
        en  = '0;
        for (int i = SSD_DIGITS - 1; i >= 1; i--) begin
            any   = any | (|bcd[4*i +: 4]);
            en[i] = any;
        end
        en[0] = 1'b1;
        return en;
    endfunction

endpackage

// File: rtl/ssd_bin2bcd_if.sv
// Request/result bundle between arithmetic result logic and the BCD converter.
interface ssd_bin2bcd_if #(
    parameter int unsigned W_IN = 14
) ();

    logic            start;
    logic [W_IN-1:0] bin_in;
    logic [3:0]      bcd0;
    logic [3:0]      bcd1;
    logic [3:0]      bcd2;
    logic [3:0]      bcd3;
    logic [3:0]      dig_en;
    logic            overflow;
    logic            busy;
    logic            done;

    modport master (
        output start, bin_in,
        input  bcd0, bcd1, bcd2, bcd3, dig_en, overflow, busy, done
    );

    modport slave (
        input  start, bin_in,
        output bcd0, bcd1, bcd2, bcd3, dig_en, overflow, busy, done
    );

endinterface

// File: rtl/ssd_bin2bcd_add3.sv
// Double-dabble nibble corrector: values of 5 or more get +3 before the shift.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = (din >= 4'd5) ? (din + 4'd3) : din;
    end

endmodule

// File: rtl/ssd_bin2bcd.sv
// Sequential binary-to-BCD converter (one bit per clock) with leading-zero blanking
// and overflow display, feeding four seven-segment digit decoders.
module ssd_bin2bcd
    import ssd_pkg::*;
#(
    parameter int unsigned W_IN     = 14,
    parameter bit          LZ_BLANK = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    ssd_bin2bcd_if.slave  bus
);

    localparam int unsigned CW = (W_IN > 1) ? $clog2(W_IN) : 1;
    localparam logic [SSD_DIGITS-1:0] EN_RST = LZ_BLANK ? 4'b0001 : 4'b1111;

    ssd_state_e           state;
    logic [W_IN-1:0]      work;
    logic [SSD_BCD_W-1:0] scratch;
    logic [SSD_BCD_W-1:0] corr;
    logic [CW-1:0]        cnt;
    logic                 ovf_pend;

    for (genvar g = 0; g < SSD_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (scratch[4*g +: 4]),
            .dout (corr[4*g +: 4])
        );
    end

    // Displayed outputs change only on the DONE edge; scratch is never exposed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            work        <= '0;
            scratch     <= '0;
            ovf_pend    <= 1'b0;
            bus.bcd0    <= '0;
            bus.bcd1    <= '0;
            bus.bcd2    <= '0;
            bus.bcd3    <= '0;
            bus.dig_en  <= EN_RST;
            bus.overflow <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    bus.busy <= 1'b0;
                    if (bus.start) begin
                        work     <= bus.bin_in;
                        scratch  <= '0;
                        cnt      <= '0;
                        ovf_pend <= (32'(bus.bin_in) > SSD_MAX_VAL);
                        bus.busy <= 1'b1;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    {scratch, work} <= {corr, work} << 1;
                    cnt             <= cnt + CW'(1);
                    if (cnt == CW'(W_IN - 1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (ovf_pend) begin
                        bus.bcd0     <= SSD_OVF_DIGIT;
                        bus.bcd1     <= SSD_OVF_DIGIT;
                        bus.bcd2     <= SSD_OVF_DIGIT;
                        bus.bcd3     <= SSD_OVF_DIGIT;
                        bus.dig_en   <= 4'b1111;
                        bus.overflow <= 1'b1;
                    end else begin
                        bus.bcd0     <= scratch[3:0];
                        bus.bcd1     <= scratch[7:4];
                        bus.bcd2     <= scratch[11:8];
                        bus.bcd3     <= scratch[15:12];
                        bus.dig_en   <= LZ_BLANK ? lz_enables(scratch) : 4'b1111;
                        bus.overflow <= 1'b0;
                    end
                    bus.done <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ssd_bin2bcd.sv
// Bench for ssd_bin2bcd: cycle-level reference model over two instances (blanking on/off)
// plus directed literal checks of the key conversions and handshake corner cases.
module tb_ssd_bin2bcd;

    localparam int unsigned W = 14;

    logic           clk;
    logic           rst_r;
    logic           start_r;
    logic [W-1:0]   bin_r;

    int checks = 0;
    int errors = 0;
    int dones  = 0;
    bit chk_en = 1'b0;

    ssd_bin2bcd_if #(.W_IN(W)) ifa ();
    ssd_bin2bcd_if #(.W_IN(W)) ifb ();

    assign ifa.start  = start_r;
    assign ifa.bin_in = bin_r;
    assign ifb.start  = start_r;
    assign ifb.bin_in = bin_r;

    ssd_bin2bcd #(.W_IN(W), .LZ_BLANK(1'b1)) dut_a (.clk(clk), .rst(rst_r), .bus(ifa.slave));
    ssd_bin2bcd #(.W_IN(W), .LZ_BLANK(1'b0)) dut_b (.clk(clk), .rst(rst_r), .bus(ifb.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state: expectation after each rising edge.
    int unsigned n_edge   = 0;
    bit          m_active = 1'b0;
    int unsigned m_k      = 0;
    int unsigned m_val    = 0;
    logic [15:0] e_bcd    = '0;
    logic [3:0]  ea_en    = 4'b0001;
    logic [3:0]  eb_en    = 4'b1111;
    logic        e_ovf    = 1'b0;
    logic        e_busy   = 1'b0;
    logic        e_done   = 1'b0;

    function automatic logic [15:0] to_bcd(input int unsigned v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            n_edge++;
            if (rst_r) begin
                m_active = 1'b0;
                e_bcd    = '0;
                ea_en    = 4'b0001;
                eb_en    = 4'b1111;
                e_ovf    = 1'b0;
                e_busy   = 1'b0;
                e_done   = 1'b0;
            end else begin
                e_done = 1'b0;
                if (m_active && n_edge == m_k + W + 1) begin
                    e_done = 1'b1;
                    eb_en  = 4'b1111;
                    if (m_val > 9999) begin
                        e_bcd = 16'hFFFF;
                        ea_en = 4'b1111;
                        e_ovf = 1'b1;
                    end else begin
                        e_bcd = to_bcd(m_val);
                        ea_en = {m_val >= 1000, m_val >= 100, m_val >= 10, 1'b1};
                        e_ovf = 1'b0;
                    end
                end
                e_busy = m_active && (n_edge <= m_k + W + 1);
                if (start_r && !(m_active && n_edge <= m_k + W + 1)) begin
                    m_active = 1'b1;
                    m_k      = n_edge;
                    m_val    = int'(bin_r);
                    e_busy   = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    initial begin
        logic [22:0] got_a, got_b, exp_a, exp_b;
        logic        prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                got_a = {ifa.bcd3, ifa.bcd2, ifa.bcd1, ifa.bcd0, ifa.dig_en, ifa.overflow, ifa.busy, ifa.done};
                got_b = {ifb.bcd3, ifb.bcd2, ifb.bcd1, ifb.bcd0, ifb.dig_en, ifb.overflow, ifb.busy, ifb.done};
                exp_a = {e_bcd, ea_en, e_ovf, e_busy, e_done};
                exp_b = {e_bcd, eb_en, e_ovf, e_busy, e_done};
                checks += 2;
                if (got_a !== exp_a) begin
                    errors++;
                    $display("FAIL model_lz1 t=%0t got bcd=%h en=%b ovf=%b busy=%b done=%b exp bcd=%h en=%b ovf=%b busy=%b done=%b",
                             $time, got_a[22:7], got_a[6:3], got_a[2], got_a[1], got_a[0],
                             exp_a[22:7], exp_a[6:3], exp_a[2], exp_a[1], exp_a[0]);
                end
                if (got_b !== exp_b) begin
                    errors++;
                    $display("FAIL model_lz0 t=%0t got bcd=%h en=%b ovf=%b busy=%b done=%b exp bcd=%h en=%b ovf=%b busy=%b done=%b",
                             $time, got_b[22:7], got_b[6:3], got_b[2], got_b[1], got_b[0],
                             exp_b[22:7], exp_b[6:3], exp_b[2], exp_b[1], exp_b[0]);
                end
                checks++;
                if (prev_done && ifa.done) begin
                    errors++;
                    $display("FAIL done_double t=%0t got two consecutive done cycles exp single pulse", $time);
                end
                if (ifa.done) dones++;
                prev_done = ifa.done;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic pulse_start(input int unsigned v);
        start_r = 1'b1;
        bin_r   = W'(v);
        @(negedge clk);
        start_r = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!ifa.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run(input int unsigned v, output int lat);
        pulse_start(v);
        wait_done(lat);
    endtask

    initial begin
        int lat;
        int d0;
        rst_r   = 1'b1;
        start_r = 1'b0;
        bin_r   = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_a", {ifa.bcd3, ifa.bcd2, ifa.bcd1, ifa.bcd0, ifa.dig_en, ifa.overflow, ifa.busy, ifa.done},
            {16'h0000, 4'b0001, 3'b000});
        chk("rst_b_en", 32'(ifb.dig_en), 32'(4'b1111));
        rst_r = 1'b0;
        @(negedge clk);

        run(0, lat);
        chk("lat_0", lat, W + 1);
        chk("val_0", {ifa.bcd3, ifa.bcd2, ifa.bcd1, ifa.bcd0, ifa.dig_en, ifa.overflow},
            {16'h0000, 4'b0001, 1'b0});

        run(1234, lat);
        chk("lat_1234", lat, 15);
        chk("val_1234", {ifa.bcd3, ifa.bcd2, ifa.bcd1, ifa.bcd0, ifa.dig_en}, {16'h1234, 4'b1111});
        chk("busy_with_done", 32'(ifa.busy), 32'(1'b1));
        @(negedge clk);
        chk("busy_drop", 32'(ifa.busy), 32'(1'b0));

        run(9999, lat);
        chk("val_9999", {ifa.bcd3, ifa.bcd2, ifa.bcd1, ifa.bcd0, ifa.overflow}, {16'h9999, 1'b0});
        @(negedge clk);
        run(10000, lat);
        chk("lat_10000", lat, 15);
        chk("val_10000", {ifa.bcd3, ifa.bcd2, ifa.bcd1, ifa.bcd0, ifa.dig_en, ifa.overflow},
            {16'hFFFF, 4'b1111, 1'b1});
        @(negedge clk);

        run(105, lat);
        chk("val_105", {ifa.bcd3, ifa.bcd2, ifa.bcd1, ifa.bcd0}, 32'h0105);
        chk("en_105_lz1", 32'(ifa.dig_en), 32'(4'b0111));
        chk("en_105_lz0", 32'(ifb.dig_en), 32'(4'b1111));
        @(negedge clk);

        // Starts at k+5 and k+15 are ignored; k+16 is accepted.
        d0 = dones;
        pulse_start(1234);
        repeat (4) @(negedge clk);
        start_r = 1'b1;
        bin_r   = W'(42);
        @(negedge clk);
        start_r = 1'b0;
        repeat (9) @(negedge clk);
        start_r = 1'b1;
        @(negedge clk);
        chk("ign_done", 32'(ifa.done), 32'(1'b1));
        chk("ign_val", {ifa.bcd3, ifa.bcd2, ifa.bcd1, ifa.bcd0}, 32'h1234);
        @(negedge clk);
        start_r = 1'b0;
        chk("ign_single_done", dones - d0, 1);
        wait_done(lat);
        chk("lat_42", lat, 15);
        chk("val_42", {ifa.bcd3, ifa.bcd2, ifa.bcd1, ifa.bcd0, ifa.dig_en}, {16'h0042, 4'b0011});
        @(negedge clk);

        // Reset at k+7 aborts the conversion.
        d0 = dones;
        pulse_start(8765);
        repeat (6) @(negedge clk);
        rst_r = 1'b1;
        @(negedge clk);
        rst_r = 1'b0;
        chk("abort_state", {ifa.bcd3, ifa.bcd2, ifa.bcd1, ifa.bcd0, ifa.dig_en, ifa.overflow, ifa.busy, ifa.done},
            {16'h0000, 4'b0001, 3'b000});
        repeat (20) @(negedge clk);
        chk("abort_no_done", dones - d0, 0);
        run(4321, lat);
        chk("val_4321", {ifa.bcd3, ifa.bcd2, ifa.bcd1, ifa.bcd0, ifa.dig_en}, {16'h4321, 4'b1111});

        // Random traffic with start noise and rare resets.
        for (int i = 0; i < 4000; i++) begin
            start_r = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 7))
                0:       bin_r = W'(9999);
                1:       bin_r = W'(10000);
                2:       bin_r = W'($urandom_range(10001, 16383));
                3:       bin_r = W'($urandom_range(0, 9));
                default: bin_r = W'($urandom_range(0, 9999));
            endcase
            rst_r = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        start_r = 1'b0;
        rst_r   = 1'b0;
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
